mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter and sequencer for the single data port of the simulation memory (one-cycle registered read, byte-enabled write, `ready` handshake). It sits between the core load/store unit (`core_*`, high priority) and an external loader/debug master (`ext_*`, low priority). It serialises their requests onto one memory command bus and returns read data and write acknowledges to the granted requester. A starvation counter guarantees the external master progress under continuous core traffic.

## Interface
- ADDR_W, 16, word-address width of the memory data port
- STARVE_MAX, 4, consecutive lost arbitrations after which `ext` wins; legal range 1..15
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- core_req / ext_req  input  1  request; held with its command fields until the matching `*_gnt`
- core_we / ext_we  input  1  1 = write, 0 = read
- core_addr / ext_addr  input  ADDR_W  word address
- core_wdata / ext_wdata  input  32  write data
- core_be / ext_be  input  4  byte enables (write only)
- core_gnt / ext_gnt  output  1  one-cycle pulse: command accepted
- core_rvalid / ext_rvalid  output  1  one-cycle pulse: read data valid, or write acknowledged
- core_rdata / ext_rdata  output  32  read data, valid while `*_rvalid`, held afterwards
- mem_addr  output  ADDR_W  memory word address
- mem_ren / mem_wen  output  1  memory read / write strobe; never both 1
- mem_wdata  output  32  memory write data
- mem_be  output  4  byte enables; 4'hF on reads
- mem_rdata  input  32  memory read data
- mem_ready  input  1  memory response ready

## Operation
- FSM states: IDLE, ISSUE, RESP. Single outstanding transaction.
- IDLE: if any request, arbitrate, register the winner's command onto `mem_*`, pulse the winner's `*_gnt`, latch owner, go to ISSUE. No request: stay, `mem_ren=mem_wen=0`.
- Arbitration: `core` wins unless `starve_cnt == STARVE_MAX` and `ext_req=1`, then `ext` wins.
- `starve_cnt` (4 bits): +1 when `ext_req=1` and `core` is granted, saturating at STARVE_MAX; cleared when `ext` is granted or when `ext_req=0` in IDLE.
- ISSUE: command held for exactly one edge (memory samples it); then `mem_ren`, `mem_wen`, and `mem_be` go to 0. `mem_addr` and `mem_wdata` hold their values. Go to RESP.
- RESP: wait for `mem_ready=1`. On that edge:
  - reads: capture `mem_rdata` into the owner's `*_rdata`;
  - both reads and writes: pulse the owner's `*_rvalid`, return to IDLE.
  - `mem_ready=0` holds RESP indefinitely. There is no timeout.
- The arbiter never drives `mem_ren=1` and `mem_wen=1` together. The memory's write-through bypass is unused.
- The non-owner's `*_rdata` is unchanged by any transaction.
- Requests arriving in ISSUE/RESP are ignored until the next IDLE cycle. Requester fields are sampled only at the granting edge.

## Timing
- Reset (asynchronous assert, synchronous release): state IDLE, `starve_cnt=0`, owner=core. All outputs 0, including `mem_addr`, `mem_wdata`, `mem_be`, and both `*_rdata`.
- Read latency: request seen at edge E0 → `gnt` and `mem_ren` high after E0 → memory samples at E1 → `mem_rdata` valid after E1 → `rvalid` high after E2 (`mem_ready=1`). Latency is 2 edges from acceptance.
- Writes: `gnt` after E0, memory writes at E1, `rvalid` ack after E2.
- Throughput: one transaction per 3 cycles. The earliest next grant is at E3, because E2 returns to IDLE.
- Reset mid-operation: the transaction is dropped with no `rvalid`. `mem_wen` falls asynchronously, so a write whose E1 has not occurred is not performed.
- Simultaneous `core_req` and `ext_req` with the counter below max: core granted, counter increments.

## Test plan
- Single core read, addr 0x0010 holding 0xDEADBEEF, `mem_ready` always 1 → `core_gnt` pulses 1 cycle after request, `core_rvalid` 2 cycles later with `core_rdata=0xDEADBEEF`; `ext_*` outputs stay 0.
- Ext write addr 0x0004, data 0x12345678, be 4'b0101, then ext read same addr (prior content 0) → read returns 0x00340078; `mem_ren` and `mem_wen` never both high.
- Both requesting continuously, STARVE_MAX=4 → grant order core,core,core,core,ext,core,core,core,core,ext; `starve_cnt` clears after each ext grant.
- `mem_ready` held 0 for 5 cycles in RESP → FSM stays in RESP, no new grant, `rvalid` exactly 1 cycle after `mem_ready` rises.
- Reset asserted (`reset=0`) during ISSUE of a core write to 0x0008 → all outputs 0 immediately, memory word 0x0008 unchanged, no `core_rvalid`. After release, a new ext read is granted normally.
- Back-to-back core reads to 0x0000 and 0x0001 → grants 3 cycles apart, `rvalid`s 3 cycles apart, correct data for each.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter/sequencer for the single data port of the simulation
// memory. Core is high priority; a starvation counter guarantees the external
// master a grant after STARVE_MAX consecutive lost arbitrations.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [31:0]       core_wdata,
  input  logic [3:0]        core_be,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [31:0]       core_rdata,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [31:0]       ext_wdata,
  input  logic [3:0]        ext_be,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [31:0]       ext_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  state_t              r_state,       w_state;
  logic [3:0]          r_starve_cnt,  w_starve_cnt;
  logic                r_owner_ext,   w_owner_ext;
  logic                r_owner_we,    w_owner_we;
  logic                r_core_gnt,    w_core_gnt;
  logic                r_ext_gnt,     w_ext_gnt;
  logic                r_core_rvalid, w_core_rvalid;
  logic                r_ext_rvalid,  w_ext_rvalid;
  logic [31:0]         r_core_rdata,  w_core_rdata;
  logic [31:0]         r_ext_rdata,   w_ext_rdata;
  logic [ADDR_W-1:0]   r_mem_addr,    w_mem_addr;
  logic                r_mem_ren,     w_mem_ren;
  logic                r_mem_wen,     w_mem_wen;
  logic [31:0]         r_mem_wdata,   w_mem_wdata;
  logic [3:0]          r_mem_be,      w_mem_be;
  logic                w_ext_wins;

  // State and all registered outputs; asynchronous clear drops any transaction
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_starve_cnt  <= '0;
      r_owner_ext   <= 1'b0;
      r_owner_we    <= 1'b0;
      r_core_gnt    <= 1'b0;
      r_ext_gnt     <= 1'b0;
      r_core_rvalid <= 1'b0;
      r_ext_rvalid  <= 1'b0;
      r_core_rdata  <= '0;
      r_ext_rdata   <= '0;
      r_mem_addr    <= '0;
      r_mem_ren     <= 1'b0;
      r_mem_wen     <= 1'b0;
      r_mem_wdata   <= '0;
      r_mem_be      <= '0;
    end else begin
      r_state       <= w_state;
      r_starve_cnt  <= w_starve_cnt;
      r_owner_ext   <= w_owner_ext;
      r_owner_we    <= w_owner_we;
      r_core_gnt    <= w_core_gnt;
      r_ext_gnt     <= w_ext_gnt;
      r_core_rvalid <= w_core_rvalid;
      r_ext_rvalid  <= w_ext_rvalid;
      r_core_rdata  <= w_core_rdata;
      r_ext_rdata   <= w_ext_rdata;
      r_mem_addr    <= w_mem_addr;
      r_mem_ren     <= w_mem_ren;
      r_mem_wen     <= w_mem_wen;
      r_mem_wdata   <= w_mem_wdata;
      r_mem_be      <= w_mem_be;
    end
  end

  // Arbitration, starvation counting, command sequencing and response routing.
  // Strobes and grants/rvalids default to 0 so each is a single-cycle pulse;
  // address, write data and read data hold unless explicitly updated.
  always_comb begin
    w_state       = r_state;
    w_starve_cnt  = r_starve_cnt;
    w_owner_ext   = r_owner_ext;
    w_owner_we    = r_owner_we;
    w_core_gnt    = 1'b0;
    w_ext_gnt     = 1'b0;
    w_core_rvalid = 1'b0;
    w_ext_rvalid  = 1'b0;
    w_core_rdata  = r_core_rdata;
    w_ext_rdata   = r_ext_rdata;
    w_mem_addr    = r_mem_addr;
    w_mem_ren     = 1'b0;
    w_mem_wen     = 1'b0;
    w_mem_wdata   = r_mem_wdata;
    w_mem_be      = '0;
    w_ext_wins    = ext_req && (!core_req || (r_starve_cnt == STARVE_LIM));

    case (r_state)
      IDLE: begin
        if (core_req || ext_req) begin
          w_state     = ISSUE;
          w_owner_ext = w_ext_wins;
          if (w_ext_wins) begin
            w_owner_we   = ext_we;
            w_mem_addr   = ext_addr;
            w_mem_wdata  = ext_wdata;
            w_mem_ren    = !ext_we;
            w_mem_wen    = ext_we;
            w_mem_be     = ext_we ? ext_be : 4'hF;
            w_ext_gnt    = 1'b1;
            w_starve_cnt = '0;
          end else begin
            w_owner_we   = core_we;
            w_mem_addr   = core_addr;
            w_mem_wdata  = core_wdata;
            w_mem_ren    = !core_we;
            w_mem_wen    = core_we;
            w_mem_be     = core_we ? core_be : 4'hF;
            w_core_gnt   = 1'b1;
            if (!ext_req)
              w_starve_cnt = '0;
            else if (r_starve_cnt != STARVE_LIM)
              w_starve_cnt = r_starve_cnt + 4'd1;
          end
        end else begin
          w_starve_cnt = '0;
        end
      end
      ISSUE: begin
        w_state = RESP;
      end
      RESP: begin
        if (mem_ready) begin
          w_state = IDLE;
          if (r_owner_ext) begin
            w_ext_rvalid = 1'b1;
            if (!r_owner_we) w_ext_rdata = mem_rdata;
          end else begin
            w_core_rvalid = 1'b1;
            if (!r_owner_we) w_core_rdata = mem_rdata;
          end
        end
      end
      default: begin
        w_state = IDLE;
      end
    endcase
  end

  assign core_gnt    = r_core_gnt;
  assign ext_gnt     = r_ext_gnt;
  assign core_rvalid = r_core_rvalid;
  assign ext_rvalid  = r_ext_rvalid;
  assign core_rdata  = r_core_rdata;
  assign ext_rdata   = r_ext_rdata;
  assign mem_addr    = r_mem_addr;
  assign mem_ren     = r_mem_ren;
  assign mem_wen     = r_mem_wen;
  assign mem_wdata   = r_mem_wdata;
  assign mem_be      = r_mem_be;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small behavioural memory model
// (registered read, byte-enabled write).
module tb_mem_port_arbiter;

  localparam int unsigned AW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          core_req = 1'b0, core_we = 1'b0;
  logic [AW-1:0] core_addr = '0;
  logic [31:0]   core_wdata = '0;
  logic [3:0]    core_be = '0;
  logic          core_gnt, core_rvalid;
  logic [31:0]   core_rdata;
  logic          ext_req = 1'b0, ext_we = 1'b0;
  logic [AW-1:0] ext_addr = '0;
  logic [31:0]   ext_wdata = '0;
  logic [3:0]    ext_be = '0;
  logic          ext_gnt, ext_rvalid;
  logic [31:0]   ext_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_ren, mem_wen;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_be;
  logic [31:0]   mem_rdata;
  logic          mem_ready = 1'b1;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_be(core_be), .core_gnt(core_gnt),
    .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_be(ext_be), .ext_gnt(ext_gnt),
    .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .mem_addr(mem_addr), .mem_ren(mem_ren), .mem_wen(mem_wen),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
  );

  // Memory model with a bench-side load port
  logic [31:0] mem [0:63];
  logic        ld_clr = 1'b0, ld_en = 1'b0;
  logic [5:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;

  always @(posedge clk) begin
    if (ld_clr) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
      mem_rdata <= '0;
    end else if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end else begin
      if (mem_wen) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem[mem_addr[5:0]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end
      if (mem_ren) mem_rdata <= mem[mem_addr[5:0]];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int both_hi = 0, n_core_rv = 0;
  always @(negedge clk) begin
    if (mem_ren && mem_wen) both_hi <= both_hi + 1;
    if (core_rvalid) n_core_rv <= n_core_rv + 1;
  end

  logic [121:0] outs;
  assign outs = {core_gnt, ext_gnt, core_rvalid, ext_rvalid, core_rdata, ext_rdata,
                 mem_addr, mem_ren, mem_wen, mem_wdata, mem_be};

  int tests = 0, fails = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load(input logic [5:0] a, input logic [31:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  typedef struct {
    logic        is_ext;
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
  } vec_t;

  // One complete transaction from an idle arbiter; called at a negedge.
  task automatic do_txn(input vec_t v, input string tag);
    logic [31:0] other_before;
    int waited;
    other_before = v.is_ext ? core_rdata : ext_rdata;
    if (v.is_ext) begin
      ext_req = 1'b1; ext_we = v.we; ext_addr = v.addr; ext_wdata = v.wdata; ext_be = v.be;
    end else begin
      core_req = 1'b1; core_we = v.we; core_addr = v.addr; core_wdata = v.wdata; core_be = v.be;
    end
    waited = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (v.is_ext ? ext_gnt : core_gnt) begin
        waited = c;
        break;
      end
    end
    core_req = 1'b0;
    ext_req  = 1'b0;
    check({tag, "_gnt_latency"}, waited, 1);
    check({tag, "_other_gnt"}, v.is_ext ? core_gnt : ext_gnt, 0);
    check({tag, "_cmd"}, {mem_ren, mem_wen, mem_addr, mem_be},
          {!v.we, v.we, v.addr, v.we ? v.be : 4'hF});
    if (v.we) check({tag, "_wdata"}, mem_wdata, v.wdata);
    @(negedge clk);
    check({tag, "_issue_idle"}, {mem_ren, mem_wen, mem_be, core_rvalid, ext_rvalid}, 0);
    @(negedge clk);
    check({tag, "_rvalid"}, {core_rvalid, ext_rvalid}, v.is_ext ? 2'b01 : 2'b10);
    if (!v.we) check({tag, "_rdata"}, v.is_ext ? ext_rdata : core_rdata, v.exp_rdata);
    check({tag, "_other_rdata"}, v.is_ext ? core_rdata : ext_rdata, other_before);
    @(negedge clk);
    check({tag, "_rvalid_pulse"}, {core_rvalid, ext_rvalid}, 0);
  endtask

  vec_t vecs[8];
  vec_t vpost;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0]  exp_seq;
    int          n, g, r, mrv;
    int          gcyc[2], rcyc[2];
    logic [31:0] rd[2];

    vecs[0] = '{1'b0, 1'b0, 16'h0010, 32'h0,        4'h0,    32'hDEADBEEF};
    vecs[1] = '{1'b1, 1'b1, 16'h0004, 32'h12345678, 4'b0101, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 16'h0004, 32'h0,        4'h0,    32'h00340078};
    vecs[3] = '{1'b0, 1'b1, 16'h0030, 32'hCAFEF00D, 4'b1100, 32'h0};
    vecs[4] = '{1'b0, 1'b0, 16'h0030, 32'h0,        4'h0,    32'hCAFE0000};
    vecs[5] = '{1'b1, 1'b1, 16'h0031, 32'hA5A5A5A5, 4'b0010, 32'h0};
    vecs[6] = '{1'b1, 1'b0, 16'h0031, 32'h0,        4'h0,    32'h0000A500};
    vecs[7] = '{1'b0, 1'b0, 16'h0004, 32'h0,        4'h0,    32'h00340078};

    reset = 1'b0;
    @(negedge clk);
    ld_clr = 1'b1;
    @(negedge clk);
    ld_clr = 1'b0;
    load(6'h10, 32'hDEADBEEF);
    load(6'h08, 32'hAAAA5555);
    load(6'h00, 32'h01020304);
    load(6'h01, 32'h0A0B0C0D);
    load(6'h20, 32'h5EED5EED);
    check("reset_outputs", outs, 0);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("idle_outputs", outs, 0);

    for (int i = 0; i < 8; i++) do_txn(vecs[i], $sformatf("v%0d", i));

    // Starvation: both requesting continuously
    core_req = 1'b1; core_we = 1'b0; core_addr = 16'h0010;
    ext_req  = 1'b1; ext_we  = 1'b0; ext_addr  = 16'h0004;
    exp_seq = 10'b1000010000;
    n = 0;
    for (int c = 0; c < 100 && n < 10; c++) begin
      @(negedge clk);
      if (core_gnt || ext_gnt) begin
        check($sformatf("starve_grant%0d", n), {core_gnt, ext_gnt},
              exp_seq[n] ? 2'b01 : 2'b10);
        n++;
      end
    end
    core_req = 1'b0;
    ext_req  = 1'b0;
    check("starve_grant_count", n, 10);
    repeat (3) @(negedge clk);

    // mem_ready stall in RESP; ext request during stall must be ignored
    mem_ready = 1'b0;
    core_req = 1'b1; core_we = 1'b0; core_addr = 16'h0020;
    n = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (core_gnt) begin n = c; break; end
    end
    core_req = 1'b0;
    check("stall_gnt_latency", n, 1);
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 16'h0010;
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("stall_hold%0d", c), {core_rvalid, core_gnt, ext_gnt, ext_rvalid}, 0);
    end
    mem_ready = 1'b1;
    ext_req   = 1'b0;
    @(negedge clk);
    check("stall_rvalid", core_rvalid, 1);
    check("stall_rdata", core_rdata, 32'h5EED5EED);
    @(negedge clk);
    check("stall_after", {core_rvalid, core_gnt, ext_gnt}, 0);
    @(negedge clk);

    // Reset during ISSUE of a core write
    core_req = 1'b1; core_we = 1'b1; core_addr = 16'h0008;
    core_wdata = 32'h11111111; core_be = 4'hF;
    n = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (core_gnt) begin n = c; break; end
    end
    check("rst_wr_gnt", {n[3:0], mem_wen}, {4'd1, 1'b1});
    mrv = n_core_rv;
    #1;
    reset = 1'b0;
    core_req = 1'b0;
    #1;
    check("rst_async_outputs", outs, 0);
    @(negedge clk);
    @(negedge clk);
    check("rst_mem_unchanged", mem[8], 32'hAAAA5555);
    check("rst_no_rvalid", n_core_rv, mrv);
    reset = 1'b1;
    @(negedge clk);
    vpost = '{1'b1, 1'b0, 16'h0008, 32'h0, 4'h0, 32'hAAAA5555};
    do_txn(vpost, "post_rst");

    // Back-to-back core reads
    core_req = 1'b1; core_we = 1'b0; core_addr = 16'h0000;
    g = 0; r = 0;
    gcyc[0] = 0; gcyc[1] = 0; rcyc[0] = 0; rcyc[1] = 0; rd[0] = '0; rd[1] = '0;
    for (int c = 0; c < 40 && r < 2; c++) begin
      @(negedge clk);
      if (core_gnt && g < 2) begin
        gcyc[g] = cyc;
        g++;
        if (g == 1) core_addr = 16'h0001;
        else core_req = 1'b0;
      end
      if (core_rvalid && r < 2) begin
        rcyc[r] = cyc;
        rd[r] = core_rdata;
        r++;
      end
    end
    core_req = 1'b0;
    check("b2b_counts", {g[3:0], r[3:0]}, {4'd2, 4'd2});
    check("b2b_gnt_spacing", gcyc[1] - gcyc[0], 3);
    check("b2b_rvalid_spacing", rcyc[1] - rcyc[0], 3);
    check("b2b_latency", rcyc[0] - gcyc[0], 2);
    check("b2b_rdata0", rd[0], 32'h01020304);
    check("b2b_rdata1", rd[1], 32'h0A0B0C0D);

    @(negedge clk);
    check("ren_wen_exclusive", both_hi, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
